// File: rtl/trap_ctrl.sv
// trap_ctrl: sequencer between the execute stage, the CSR file and the fetch unit.
// An ecall saves mepc/mcause and then reads mtvec. An mret reads mepc. Either path
// ends with a PC redirect handed to the IFU over a valid/ready handshake.
// Optional macro TRAP_MSTATUS_EN adds the mstatus save (ecall) and restore (mret) steps.
module trap_ctrl #(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12,
    parameter logic [CSR_AW-1:0] ADDR_MSTATUS = 12'h300,
    parameter logic [CSR_AW-1:0] ADDR_MTVEC   = 12'h305,
    parameter logic [CSR_AW-1:0] ADDR_MEPC    = 12'h341,
    parameter logic [CSR_AW-1:0] ADDR_MCAUSE  = 12'h342
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_type,
    input  logic [XLEN-1:0]   req_pc,
    input  logic [XLEN-1:0]   req_cause,
    output logic [CSR_AW-1:0] csr_raddr,
    input  logic [XLEN-1:0]   csr_rdata,
    output logic              csr_wen,
    output logic [CSR_AW-1:0] csr_waddr,
    output logic [XLEN-1:0]   csr_wdata,
    output logic              redir_valid,
    input  logic              redir_ready,
    output logic [XLEN-1:0]   redir_pc,
    output logic              busy
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_SAVE_EPC   = 3'd1;
    localparam logic [2:0] S_SAVE_CAUSE = 3'd2;
    localparam logic [2:0] S_RD_TVEC    = 3'd3;
    localparam logic [2:0] S_RD_EPC     = 3'd4;
    localparam logic [2:0] S_REDIRECT   = 3'd5;
`ifdef TRAP_MSTATUS_EN
    localparam logic [2:0] S_SAVE_STATUS = 3'd6;
    localparam logic [2:0] S_RST_STATUS  = 3'd7;
`endif

    logic [2:0]      state;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] target_q;

    // CSR values are word aligned; the low two bits (mtvec mode, stray bits) are dropped
    logic [XLEN-1:0] rdata_aligned;
    assign rdata_aligned = {csr_rdata[XLEN-1:2], 2'b00};

    // Sequence state and latched request/target
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            pc_q     <= '0;
            cause_q  <= '0;
            target_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        pc_q    <= req_pc;
                        cause_q <= req_cause;
`ifdef TRAP_MSTATUS_EN
                        state   <= req_type ? S_RST_STATUS : S_SAVE_EPC;
`else
                        state   <= req_type ? S_RD_EPC : S_SAVE_EPC;
`endif
                    end
                end
                S_SAVE_EPC: state <= S_SAVE_CAUSE;
`ifdef TRAP_MSTATUS_EN
                S_SAVE_CAUSE:  state <= S_SAVE_STATUS;
                S_SAVE_STATUS: state <= S_RD_TVEC;
                S_RST_STATUS:  state <= S_RD_EPC;
`else
                S_SAVE_CAUSE:  state <= S_RD_TVEC;
`endif
                S_RD_TVEC, S_RD_EPC: begin
                    target_q <= rdata_aligned;
                    state    <= S_REDIRECT;
                end
                S_REDIRECT: begin
                    if (redir_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // CSR port drive decoded from state; writes are suppressed while reset is held
    // so an aborted sequence cannot land a partial save in the CSR file
    always_comb begin
        csr_wen   = 1'b0;
        csr_waddr = '0;
        csr_wdata = '0;
        csr_raddr = '0;
        case (state)
            S_SAVE_EPC: begin
                csr_wen   = 1'b1;
                csr_waddr = ADDR_MEPC;
                csr_wdata = {pc_q[XLEN-1:2], 2'b00};
            end
            S_SAVE_CAUSE: begin
                csr_wen   = 1'b1;
                csr_waddr = ADDR_MCAUSE;
                csr_wdata = cause_q;
            end
`ifdef TRAP_MSTATUS_EN
            // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M
            S_SAVE_STATUS: begin
                csr_raddr     = ADDR_MSTATUS;
                csr_wen       = 1'b1;
                csr_waddr     = ADDR_MSTATUS;
                csr_wdata     = csr_rdata;
                csr_wdata[7]  = csr_rdata[3];
                csr_wdata[3]  = 1'b0;
                csr_wdata[12:11] = 2'b11;
            end
            // Trap return: MIE <= MPIE, MPIE <= 1, MPP stays M
            S_RST_STATUS: begin
                csr_raddr     = ADDR_MSTATUS;
                csr_wen       = 1'b1;
                csr_waddr     = ADDR_MSTATUS;
                csr_wdata     = csr_rdata;
                csr_wdata[3]  = csr_rdata[7];
                csr_wdata[7]  = 1'b1;
                csr_wdata[12:11] = 2'b11;
            end
`endif
            S_RD_TVEC: csr_raddr = ADDR_MTVEC;
            S_RD_EPC:  csr_raddr = ADDR_MEPC;
            default: ;
        endcase
        if (rst) begin
            csr_wen   = 1'b0;
            csr_waddr = '0;
            csr_wdata = '0;
        end
    end

    assign req_ready   = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign redir_valid = (state == S_REDIRECT);
    assign redir_pc    = (state == S_REDIRECT) ? target_q : '0;

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Sequencer on the initiator side of the CSR file's trap interface. Accepts ecall/mret requests from the execute stage and drives the CSR file's write and read ports over several cycles: save mepc/mcause, then read mtvec; or, for mret, read mepc. It then issues a PC redirect to the fetch unit over a valid/ready handshake. Sits between EXU, CSR file and IFU.

Parameters:
XLEN, 32, data/PC width
CSR_AW, 12, CSR address width
ADDR_MSTATUS, 12'h300, mstatus address
ADDR_MTVEC, 12'h305, mtvec address
ADDR_MEPC, 12'h341, mepc address
ADDR_MCAUSE, 12'h342, mcause address

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, synchronous, active-high
req_valid  input  1  trap request valid
req_ready  output  1  high only in IDLE
req_type  input  1  0=ecall, 1=mret
req_pc  input  XLEN  PC of trapping instruction
req_cause  input  XLEN  cause code (ecall from M-mode = 32'h0000000b)
csr_raddr  output  CSR_AW  CSR read address
csr_rdata  input  XLEN  CSR read data, combinational from csr_raddr
csr_wen  output  1  CSR write enable, one cycle per write
csr_waddr  output  CSR_AW  CSR write address
csr_wdata  output  XLEN  CSR write data
redir_valid  output  1  redirect target valid
redir_ready  input  1  IFU accepts redirect
redir_pc  output  XLEN  redirect target
busy  output  1  state != IDLE

Behaviour:
- States: IDLE, SAVE_EPC, SAVE_CAUSE, RD_TVEC, RD_EPC, REDIRECT (plus SAVE_STATUS / RST_STATUS with the option).
- Reset: state=IDLE; redir_valid=0, redir_pc=0, csr_wen=0, csr_waddr=0, csr_wdata=0, csr_raddr=0, busy=0; internal pc_q, cause_q and target_q are cleared to 0. Reset during any state aborts the sequence, with no further CSR writes and no redirect.
- Accept: a request is accepted on req_valid && req_ready. req_pc and req_cause are latched into pc_q and cause_q. Inputs are ignored outside IDLE.
- Ecall path: IDLE -> SAVE_EPC -> SAVE_CAUSE -> RD_TVEC -> REDIRECT.
  - SAVE_EPC: csr_wen=1, waddr=MEPC, wdata={pc_q[31:2],2'b00}.
  - SAVE_CAUSE: csr_wen=1, waddr=MCAUSE, wdata=cause_q.
  - RD_TVEC: raddr=MTVEC; target_q <= {csr_rdata[31:2],2'b00}. mtvec mode bits are ignored, because exceptions always go to base.
- Mret path: IDLE -> RD_EPC -> REDIRECT.
  - RD_EPC: raddr=MEPC; target_q <= {csr_rdata[31:2],2'b00}.
- REDIRECT: redir_valid=1, redir_pc=target_q. Both are held stable until redir_ready; on redir_ready -> IDLE, and redir_valid drops the next cycle.
  - redir_ready arriving early (before REDIRECT) is ignored.
  - A new request may be accepted the cycle after the handshake completes, not in the same cycle.
- csr_wen is combinational from state: exactly one pulse per write state, never in IDLE, RD_* or REDIRECT. csr_waddr/wdata are 0 when csr_wen=0.
- csr_raddr is combinational from state; it is 0 outside the read states.
- Latency, request accept to redir_valid, without option: ecall 4 cycles, mret 2 cycles.
- Unknown req_type is impossible (1 bit). Back-to-back requests are serialized by req_ready.

Optional Feature:
Macro TRAP_MSTATUS_EN.
- Defined:
  - Ecall inserts SAVE_STATUS after SAVE_CAUSE. raddr=MSTATUS; csr_wen=1, waddr=MSTATUS; wdata = rdata with MPIE(bit7)=MIE(bit3), MIE=0, MPP(bits12:11)=2'b11.
  - Mret inserts RST_STATUS before RD_EPC. wdata = rdata with MIE=MPIE, MPIE=1, MPP=2'b11.
  - Latency becomes ecall 5, mret 3.
- Undefined: mstatus is never read or written; the state encodings for these states are absent.

Test Plan:
- Ecall, mtvec=32'h80000100: req_pc=32'h80000020, cause=32'hb -> writes mepc=32'h80000020 then mcause=32'hb on consecutive cycles; redir_pc=32'h80000100 four cycles after accept.
- Mret, mepc=32'h80000024: -> no csr_wen pulses; redir_pc=32'h80000024 two cycles after accept.
- mtvec=32'h80000101 (vectored), ecall -> redir_pc=32'h80000100.
- redir_ready held low 5 cycles in REDIRECT -> redir_valid and redir_pc stable; req_ready=0; a new req_valid is ignored. Release -> IDLE next cycle; the next request is accepted.
- rst asserted in SAVE_CAUSE -> next cycle all outputs 0, no mcause write, no redirect; a subsequent mret completes normally.
- TRAP_MSTATUS_EN, mstatus=32'h00000008: ecall -> mstatus written 32'h00001880; then mret -> mstatus written 32'h00001888; latencies 5 and 3.
